// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWB       = 2;
  localparam int WB_ALU    = 0;
  localparam int WB_LD     = 1;

  // Address width; a 2-entry file still needs one address bit.
  function automatic int aw_of(input int nregs);
    if (nregs <= 2) begin
      return 1;
    end else begin
      return $clog2(nregs);
    end
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy flags: issue sets, retiring write-back clears, set wins over clear.
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = aw_of(NREGS_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  input  logic [NWB-1:0]    i_wb_en,
  input  logic [NWB*AW-1:0] i_wb_addr,
  input  logic [NWB-1:0]    i_wb_clr,
  output logic [NREGS-1:0]  o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  // Decode issue and retiring write-backs into one-hot set/clear vectors; x0 is never tracked.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_valid) begin
      w_set[i_iss_rd] = 1'b1;
    end else begin
      w_set = '0;
    end
    for (int p = 0; p < NWB; p++) begin
      if (i_wb_en[p] && i_wb_clr[p]) begin
        w_clr[i_wb_addr[p*AW +: AW]] = 1'b1;
      end else begin
        w_clr = w_clr;
      end
    end
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
  end

  // Busy flops; OR-ing the set after the clear mask gives the newer producer ownership.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NRD combinational reads, two write-back ports, x0 = 0, busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = NRD_DEF,
  localparam int AW    = aw_of(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic                i_iss_valid,
  input  logic [AW-1:0]       i_iss_rd,
  input  logic [NWB-1:0]      i_wb_en,
  input  logic [NWB*AW-1:0]   i_wb_addr,
  input  logic [NWB*XLEN-1:0] i_wb_data,
  input  logic [NWB-1:0]      i_wb_clr,
  output logic [3:0]          o_dbg_nib
);

  logic [XLEN-1:0]  r_bank [NREGS];
  logic [3:0]       r_dbg_nib;
  logic [NREGS-1:0] w_busy;
  logic [NWB-1:0]   w_wr;
  logic             w_dbg_we;
  logic [3:0]       w_dbg_nib;

  regfile_sb_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .i_wb_clr    (i_wb_clr),
    .o_busy      (w_busy)
  );

  // Qualified writes (x0 dropped) and the debug nibble, where the load port overrides the ALU port.
  always_comb begin
    w_wr      = '0;
    w_dbg_we  = 1'b0;
    w_dbg_nib = r_dbg_nib;
    for (int p = 0; p < NWB; p++) begin
      if (i_wb_en[p] && (i_wb_addr[p*AW +: AW] != {AW{1'b0}})) begin
        w_wr[p]   = 1'b1;
        w_dbg_we  = 1'b1;
        w_dbg_nib = i_wb_data[p*XLEN +: 4];
      end else begin
        w_wr[p] = 1'b0;
      end
    end
  end

  // Register bank; the later loop iteration (load port) wins on an address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_bank[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (w_wr[p]) begin
          r_bank[i_wb_addr[p*AW +: AW]] <= i_wb_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Debug nibble holds unless a non-x0 write commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbg_nib <= 4'h0;
    end else if (w_dbg_we) begin
      r_dbg_nib <= w_dbg_nib;
    end else begin
      r_dbg_nib <= r_dbg_nib;
    end
  end

  assign o_dbg_nib = r_dbg_nib;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_rbusy;

    assign w_addr = i_rd_addr[gi*AW +: AW];

    // Read mux with optional forwarding; a re-issue of the same register keeps it busy.
    always_comb begin
      w_data  = r_bank[w_addr];
      w_rbusy = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWB; p++) begin
        if (w_wr[p] && (i_wb_addr[p*AW +: AW] == w_addr)) begin
          w_data = i_wb_data[p*XLEN +: XLEN];
          if (i_wb_clr[p] && !(i_iss_valid && (i_iss_rd == w_addr))) begin
            w_rbusy = 1'b0;
          end else begin
            w_rbusy = w_rbusy;
          end
        end else begin
          w_data = w_data;
        end
      end
`else
      w_data  = w_data;
`endif
      if (w_addr == {AW{1'b0}}) begin
        w_data  = '0;
        w_rbusy = 1'b0;
      end else begin
        w_rbusy = w_rbusy;
      end
    end

    assign o_rd_data[gi*XLEN +: XLEN] = w_data;
    assign o_rd_busy[gi]              = w_rbusy;
  end

endmodule
